// File: rtl/piso_tx_scheduler.sv
// Round-robin scheduler sharing one WIDTH-bit PISO among NUM_REQ requesters (one load + WIDTH shifts per frame).
// Define PISO_TX_SCHED_GAP_EN to insert one GAP cycle after each frame; arbitration then happens in GAP.
module piso_tx_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4,
  parameter int GID_W   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  // Handshake: req[i] is a level held until ack[i] pulses for one cycle; req_data slice i is
  // captured on that same edge, so the requester may drop req or change data from the next cycle.
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       ack,
  output logic                     shift_or_loadbar,
  output logic [WIDTH-1:0]         par_data,
  output logic                     ser_valid,
  output logic                     frame_done,
  output logic                     busy,
  output logic [GID_W-1:0]         grant_id
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [GID_W-1:0] LAST_ID  = GID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SHIFT = 2'd2, GAP = 2'd3} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GID_W-1:0] ptr_q, winner, idx;
  logic [WIDTH-1:0] words [NUM_REQ];
  logic             last_bit, arb_en, any_req, grant;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) words[i] = req_data[i*WIDTH +: WIDTH];
  end

  // Search starts at ptr_q and wraps, so the requester served last is searched last.
  always_comb begin
    any_req = 1'b0;
    winner  = '0;
    idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = GID_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        winner  = idx;
      end
    end
  end

  assign last_bit = (state_q == SHIFT) && (cnt_q == LAST_CNT);
`ifdef PISO_TX_SCHED_GAP_EN
  assign arb_en = (state_q == IDLE) || (state_q == GAP);
`else
  assign arb_en = (state_q == IDLE) || last_bit;
`endif
  assign grant = arb_en && any_req && !rst;

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    ack              = '0;
    shift_or_loadbar = 1'b1;
    ser_valid        = 1'b0;
    frame_done       = 1'b0;
    busy             = 1'b1;
    if (grant) ack[winner] = 1'b1;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (grant) state_d = LOAD;
      end
      LOAD: begin
        shift_or_loadbar = 1'b0;
        state_d          = SHIFT;
        cnt_d            = '0;
      end
      SHIFT: begin
        ser_valid = 1'b1;
        cnt_d     = cnt_q + CNT_W'(1);
        if (last_bit) begin
          // A reset landing on the last bit aborts the frame, so no completion is reported.
          frame_done = !rst;
`ifdef PISO_TX_SCHED_GAP_EN
          state_d = GAP;
`else
          state_d = grant ? LOAD : IDLE;
`endif
        end
      end
      GAP: state_d = grant ? LOAD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ptr_q    <= '0;
      par_data <= '0;
      grant_id <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (grant) begin
        par_data <= words[winner];
        grant_id <= winner;
        ptr_q    <= (winner == LAST_ID) ? '0 : winner + GID_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_piso_tx_scheduler.sv
// Bench for piso_tx_scheduler: directed scenarios plus randomized traffic against a round-robin reference model.
// Works with or without PISO_TX_SCHED_GAP_EN defined.
module tb_piso_tx_scheduler;
  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 4;
  localparam int GID_W   = 2;
`ifdef PISO_TX_SCHED_GAP_EN
  localparam int GAP = 1;
`else
  localparam int GAP = 0;
`endif
  localparam int PERIOD = WIDTH + 1 + GAP;

  logic                     clk;
  logic                     rst;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       ack;
  logic                     shift_or_loadbar;
  logic [WIDTH-1:0]         par_data;
  logic                     ser_valid;
  logic                     frame_done;
  logic                     busy;
  logic [GID_W-1:0]         grant_id;

  int errors = 0;
  int checks = 0;

  piso_tx_scheduler #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .GID_W(GID_W)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
    .shift_or_loadbar(shift_or_loadbar), .par_data(par_data), .ser_valid(ser_valid),
    .frame_done(frame_done), .busy(busy), .grant_id(grant_id)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // External PISO driven by the scheduler: loads when shift_or_loadbar=0, MSB out first
  logic [WIDTH-1:0] piso_q;
  logic             piso_out;
  always @(posedge clk) begin
    if (!shift_or_loadbar) piso_q <= par_data;
    else                   piso_q <= piso_q << 1;
  end
  assign piso_out = piso_q[WIDTH-1];

  // Driver tasks
  task automatic apply_reset;
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic drain(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      req = '0;
      #1;
      if (!busy && ack == '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    logic [NUM_REQ+WIDTH+GID_W+3:0] got, exp;
    rst = 1'b1;
    req = '0;
    req_data = '0;
    repeat (2) @(negedge clk);
    #1;
    got = {ack, shift_or_loadbar, par_data, ser_valid, frame_done, busy, grant_id};
    exp = {{NUM_REQ{1'b0}}, 1'b1, {WIDTH{1'b0}}, 3'b000, {GID_W{1'b0}}};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_values: got %0h expected %0h", got, exp); end
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({shift_or_loadbar, busy, ser_valid, ack} !== {3'b100, {NUM_REQ{1'b0}}}) begin
        errors++;
        $display("FAIL reset_idle: sol/busy/valid/ack got %b%b%b %b expected 100 0000", shift_or_loadbar, busy, ser_valid, ack);
      end
    end
  endtask

  task automatic test_single;
    logic [WIDTH-1:0] w;
    bit ok;
    w = 4'b1001;
    apply_reset;
    @(negedge clk);
    req = 4'b0100;
    req_data = '0;
    req_data[2*WIDTH +: WIDTH] = w;
    #1;
    checks++;
    if (ack !== 4'b0100) begin errors++; $display("FAIL single_ack: got %b expected 0100", ack); end
    @(negedge clk);
    req = '0;
    #1;
    checks++;
    if ({shift_or_loadbar, busy, ser_valid, par_data, grant_id, ack} !== {3'b010, w, 2'd2, 4'b0000}) begin
      errors++;
      $display("FAIL single_load: sol=%b busy=%b valid=%b par=%b gid=%0d ack=%b, expected 0 1 0 1001 2 0000",
               shift_or_loadbar, busy, ser_valid, par_data, grant_id, ack);
    end
    for (int b = 0; b < WIDTH + GAP; b++) begin
      @(negedge clk);
      #1;
      if (b < WIDTH) begin
        checks++;
        if (ser_valid !== 1'b1 || piso_out !== w[WIDTH-1-b]) begin
          errors++;
          $display("FAIL single_bit%0d: valid=%b out=%b expected 1 %b", b, ser_valid, piso_out, w[WIDTH-1-b]);
        end
        checks++;
        if (frame_done !== (b == WIDTH - 1)) begin
          errors++;
          $display("FAIL single_done%0d: got %b expected %b", b, frame_done, (b == WIDTH - 1));
        end
      end else begin
        checks++;
        if ({shift_or_loadbar, busy, ser_valid} !== 3'b110) begin
          errors++;
          $display("FAIL single_gap: sol/busy/valid got %b%b%b expected 110", shift_or_loadbar, busy, ser_valid);
        end
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if ({shift_or_loadbar, busy, ser_valid} !== 3'b100) begin
      errors++;
      $display("FAIL single_idle: sol/busy/valid got %b%b%b expected 100", shift_or_loadbar, busy, ser_valid);
    end
    drain(ok);
  endtask

  task automatic test_round_robin;
    logic [NUM_REQ-1:0] e;
    int n, last_c;
    bit ok;
    n = 0;
    last_c = 0;
    apply_reset;
    for (int i = 0; i < NUM_REQ; i++) req_data[i*WIDTH +: WIDTH] = WIDTH'(i + 1);
    for (int c = 0; c < 60 && n < 5; c++) begin
      @(negedge clk);
      req = '1;
      #1;
      if (ack != '0) begin
        e = '0;
        e[n % NUM_REQ] = 1'b1;
        checks++;
        if (ack !== e) begin errors++; $display("FAIL rr_order%0d: got %b expected %b", n, ack, e); end
        if (n > 0) begin
          checks++;
          if (c - last_c != PERIOD) begin
            errors++;
            $display("FAIL rr_period%0d: got %0d expected %0d", n, c - last_c, PERIOD);
          end
        end
        last_c = c;
        n++;
      end
    end
    checks++;
    if (n != 5) begin errors++; $display("FAIL rr_timeout: acks seen %0d expected 5", n); end
    drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rr_drain: busy=%b expected 0", busy); end
  endtask

  task automatic test_late_request;
    logic [NUM_REQ-1:0] e;
    bit ok;
    apply_reset;
    @(negedge clk);
    req = 4'b1000;
    req_data = '0;
    req_data[3*WIDTH +: WIDTH] = 4'h5;
    #1;
    checks++;
    if (ack !== 4'b1000) begin errors++; $display("FAIL late_first_ack: got %b expected 1000", ack); end
    @(negedge clk);
    req = '0;
    @(negedge clk);
    @(negedge clk);
    req = 4'b0010;
    req_data[1*WIDTH +: WIDTH] = 4'hA;
    #1;
    checks++;
    if (ack !== 4'b0000) begin errors++; $display("FAIL late_wait_s1: got %b expected 0000", ack); end
    for (int s = 2; s < WIDTH + GAP; s++) begin
      @(negedge clk);
      #1;
      e = (s == WIDTH - 1 + GAP) ? 4'b0010 : 4'b0000;
      checks++;
      if (ack !== e) begin errors++; $display("FAIL late_ack_s%0d: got %b expected %b", s, ack, e); end
    end
    @(negedge clk);
    req = '0;
    #1;
    checks++;
    if ({shift_or_loadbar, grant_id, par_data} !== {1'b0, 2'd1, 4'hA}) begin
      errors++;
      $display("FAIL late_load: sol=%b gid=%0d par=%h expected 0 1 a", shift_or_loadbar, grant_id, par_data);
    end
    drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL late_drain: busy=%b expected 0", busy); end
  endtask

  task automatic test_mid_reset;
    logic [NUM_REQ+WIDTH+GID_W+3:0] got, exp;
    bit ok;
    apply_reset;
    @(negedge clk);
    req = 4'b0100;
    req_data = '0;
    req_data[2*WIDTH +: WIDTH] = 4'b0110;
    #1;
    checks++;
    if (ack !== 4'b0100) begin errors++; $display("FAIL midrst_ack: got %b expected 0100", ack); end
    @(negedge clk);
    req = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (frame_done !== 1'b0) begin errors++; $display("FAIL midrst_nodone: got %b expected 0", frame_done); end
    @(negedge clk);
    #1;
    got = {ack, shift_or_loadbar, par_data, ser_valid, frame_done, busy, grant_id};
    exp = {{NUM_REQ{1'b0}}, 1'b1, {WIDTH{1'b0}}, 3'b000, {GID_W{1'b0}}};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL midrst_values: got %0h expected %0h", got, exp); end
    rst = 1'b0;
    req = '1;
    #1;
    checks++;
    if (ack !== 4'b0001) begin errors++; $display("FAIL midrst_first_grant: got %b expected 0001", ack); end
    drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL midrst_drain: busy=%b expected 0", busy); end
  endtask

  task automatic test_withdraw;
    int bad;
    bad = 0;
    apply_reset;
    @(negedge clk);
    req = 4'b0001;
    req_data = '0;
    req_data[3*WIDTH +: WIDTH] = 4'hF;
    #1;
    checks++;
    if (ack !== 4'b0001) begin errors++; $display("FAIL withdraw_first_ack: got %b expected 0001", ack); end
    @(negedge clk);
    req = '0;
    @(negedge clk);
    @(negedge clk);
    req = 4'b1000;
    #1;
    if (ack != '0) bad++;
    for (int n = 0; n < WIDTH - 1 + GAP + 3; n++) begin
      @(negedge clk);
      req = '0;
      #1;
      if (ack != '0) bad++;
      if (n == WIDTH - 2 + GAP) begin
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL withdraw_idle: busy=%b expected 0", busy); end
      end
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL withdraw_noack: acks seen %0d expected 0", bad); end
  endtask

  // Randomized traffic: ack legality and order from a round-robin model, frame bits from a scoreboard
  task automatic test_random;
    logic [WIDTH-1:0]   exp_q[$];
    logic [WIDTH-1:0]   dat [NUM_REQ];
    logic [WIDTH-1:0]   cur, want_word;
    logic [NUM_REQ-1:0] r, want;
    int ptr, next_arb, w, idx, nb;
    ptr = 0;
    next_arb = 0;
    nb = 0;
    r = '0;
    cur = '0;
    for (int i = 0; i < NUM_REQ; i++) dat[i] = '0;
    apply_reset;
    for (int c = 0; c < 430; c++) begin
      @(negedge clk);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (c < 400 && !r[i] && $urandom_range(0, 3) == 0) begin
          r[i] = 1'b1;
          dat[i] = WIDTH'($urandom);
        end
        req_data[i*WIDTH +: WIDTH] = dat[i];
      end
      req = r;
      #1;
      w = -1;
      if (c >= next_arb) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          idx = (ptr + k) % NUM_REQ;
          if (w < 0 && r[idx]) w = idx;
        end
      end
      want = '0;
      if (w >= 0) want[w] = 1'b1;
      checks++;
      if (ack !== want) begin errors++; $display("FAIL rand_ack c%0d: got %b expected %b", c, ack, want); end
      if (w >= 0) begin
        exp_q.push_back(dat[w]);
        ptr = (w + 1) % NUM_REQ;
        next_arb = c + PERIOD;
        r[w] = 1'b0;
      end
      if (ser_valid) begin
        cur = {cur[WIDTH-2:0], piso_out};
        nb++;
        checks++;
        if (frame_done !== (nb == WIDTH)) begin
          errors++;
          $display("FAIL rand_done c%0d: got %b expected %b", c, frame_done, (nb == WIDTH));
        end
        if (nb == WIDTH) begin
          want_word = (exp_q.size() > 0) ? exp_q.pop_front() : ~cur;
          checks++;
          if (cur !== want_word) begin errors++; $display("FAIL rand_frame c%0d: got %h expected %h", c, cur, want_word); end
          nb = 0;
        end
      end else if (frame_done !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL rand_stray_done c%0d: got 1 expected 0", c);
      end
    end
    checks++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rand_drain: pending frames %0d busy=%b expected 0 0", exp_q.size(), busy);
    end
  endtask

  // Sequencing and final report
  initial begin
    rst = 1'b1;
    req = '0;
    req_data = '0;
    test_reset;
    test_single;
    test_round_robin;
    test_late_request;
    test_mid_reset;
    test_withdraw;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/piso_tx_scheduler.md
Name: piso_tx_scheduler

Overview:
- Shares one WIDTH-bit parallel-in/serial-out shift register (PISO) among NUM_REQ requesters using round-robin arbitration.
- Sequences the PISO: one load cycle followed by WIDTH shift cycles per frame, and flags the cycles where the PISO output carries a valid frame bit.
- Sits between requester logic and the PISO's shift_or_loadbar and parallel data pins.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 4, frame width in bits; must match the PISO width (2..16).
- GID_W, 2, grant index width; must equal $clog2(NUM_REQ).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  request per requester; level, held until acked.
- req_data  in  NUM_REQ*WIDTH  flattened words; requester i owns bits [i*WIDTH +: WIDTH].
- ack  out  NUM_REQ  one-hot, one-cycle pulse: request accepted, data captured on this edge.
- shift_or_loadbar  out  1  PISO control: 0 = load, 1 = shift.
- par_data  out  WIDTH  word presented to the PISO parallel inputs.
- ser_valid  out  1  high while the PISO serial output holds a frame bit.
- frame_done  out  1  one-cycle pulse on the last bit of a frame.
- busy  out  1  high in LOAD and SHIFT.
- grant_id  out  GID_W  index of the requester owning the current frame.

Behaviour:
- Reset values: ack=0, shift_or_loadbar=1, par_data=0, ser_valid=0, frame_done=0, busy=0, grant_id=0. FSM goes to IDLE, bit counter to 0, and the round-robin pointer is set so that requester 0 has highest priority.
- Reset asserted mid-frame aborts the frame immediately. No ack or frame_done is issued for the aborted frame.
- PISO model:
  - Load on a rising edge when shift_or_loadbar=0.
  - Otherwise shift toward the output.
  - Serial output = stored bit WIDTH-1 first (MSB-first).
- FSM states: IDLE, LOAD, SHIFT.
- Arbitration point: in IDLE, or in the last SHIFT cycle (counter == WIDTH-1).
  - If any req is high, the winner is the first requester at or after the pointer (wrapping).
  - ack[winner]=1 that cycle.
  - req_data slice is captured into par_data and winner into grant_id on that edge.
  - Pointer moves to winner+1 mod NUM_REQ.
- IDLE: shift_or_loadbar=1, busy=0. On a grant, go to LOAD.
- LOAD (exactly 1 cycle): shift_or_loadbar=0, busy=1, ser_valid=0. Then go to SHIFT with counter=0.
- SHIFT (WIDTH cycles):
  - shift_or_loadbar=1, ser_valid=1, busy=1; counter increments each cycle.
  - On counter == WIDTH-1: frame_done=1.
  - Then go to LOAD if a grant was made that cycle (back-to-back frame, no gap), else IDLE.
- Latency: req asserted in IDLE → ack the same cycle → LOAD next cycle → first valid bit 2 cycles after ack.
- Frame period when back-to-back: WIDTH+1 cycles.
- Requests arriving during LOAD or non-final SHIFT cycles wait; they are not lost as long as req is held.
- A requester may drop req or change req_data from the cycle after its ack.
- par_data holds its captured value until the next capture.
- Simultaneous requests: strictly round-robin; no requester is granted twice while another is pending.
- Deasserting req before ack: the request is withdrawn, no ack.

Optional Feature:
- Macro PISO_TX_SCHED_GAP_EN.
- When defined: after each frame, one mandatory GAP state (shift_or_loadbar=1, busy=1, ser_valid=0) precedes any next LOAD.
  - Arbitration moves from the last SHIFT cycle to the GAP cycle.
  - Back-to-back frame period becomes WIDTH+2.
  - frame_done timing is unchanged.
- When undefined: no GAP state; behaviour as above.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, req=0 → all outputs at reset values; shift_or_loadbar=1, busy=0 indefinitely.
- Single frame: req[2]=1, data[2]=4'b1001 → ack[2] pulse; next cycle shift_or_loadbar=0, par_data=1001, grant_id=2. Then 4 cycles ser_valid=1 with PISO out 1,0,0,1; frame_done on the 4th; back to IDLE.
- Round-robin: req=4'b1111 held, data i = i+1 → grant order 0,1,2,3,0. Frames back-to-back with period 5 cycles (6 with PISO_TX_SCHED_GAP_EN). Exactly one ack bit per frame.
- Late request: req[1] rises during the 2nd SHIFT cycle of requester 3's frame → ack[1] on the last SHIFT cycle, LOAD immediately after, grant_id=1. Pointer wraps correctly.
- Mid-frame reset: rst=1 on the 3rd SHIFT cycle → next cycle all outputs at reset values, no frame_done. After release, requester 0 is granted first.
- Withdraw: req[3] pulsed for 1 cycle during another requester's mid-frame → never acked; FSM returns to IDLE after the current frame.
